// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline definitions: opcodes, default memory access types,
// and the ID/EX control bundle with its bubble value.
package rv_pipe_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] LOAD_TYPE_DEFAULT  = 3'b010;
    localparam logic [1:0] STORE_TYPE_DEFAULT = 2'b10;

    typedef struct packed {
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       wb_reg_file;
        logic       memtoreg;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic [2:0] mem_load_type;
        logic [1:0] mem_store_type;
        logic [3:0] alu_ctrl;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE_CTRL = '{
        alu_src:        1'b0,
        mem_write:      1'b0,
        mem_read:       1'b0,
        wb_reg_file:    1'b0,
        memtoreg:       1'b0,
        branch:         1'b0,
        jal:            1'b0,
        jalr:           1'b0,
        mem_load_type:  LOAD_TYPE_DEFAULT,
        mem_store_type: STORE_TYPE_DEFAULT,
        alu_ctrl:       4'b0000
    };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
// Ports: id_valid/id_opcode/id_rs1/id_rs2 describe the decode-stage instruction;
// ex_valid/ex_mem_read/ex_rd describe the instruction currently in EX;
// hz flags that the ID instruction reads the register a pending EX load writes.
module load_use_detect
    import rv_pipe_pkg::*;
#(
    parameter int unsigned RADDR_W = 5
) (
    input  logic               id_valid,
    input  logic [6:0]         id_opcode,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic               ex_valid,
    input  logic               ex_mem_read,
    input  logic [RADDR_W-1:0] ex_rd,
    output logic               hz
);

    logic rs1_used;
    logic rs2_used;

    // Source-register usage by opcode; unknown opcodes read nothing.
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (id_opcode)
            OP_R, OP_STORE, OP_BRANCH: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OP_I, OP_LOAD, OP_JALR: rs1_used = 1'b1;
            OP_LUI, OP_AUIPC, OP_JAL: rs1_used = 1'b0;
            default: ;
        endcase
    end

    // x0 is never a real destination, so a load into it cannot cause a hazard.
    assign hz = id_valid & ex_valid & ex_mem_read & (ex_rd != '0)
              & ((rs1_used & (id_rs1 == ex_rd)) | (rs2_used & (id_rs2 == ex_rd)));

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion.
// Inputs: id_* decode-stage bundle, stall_in (hold), flush (kill ID instr), rst.
// Outputs: registered ex_* copies, ex_valid, and combinational hazard_stall
// which freezes PC and IF/ID while a load-use bubble is inserted.
// Optional build macro ID_EX_PERF_EN adds saturating perf_bubble_cnt and
// perf_flush_cnt outputs.
module id_ex_pipe_reg
    import rv_pipe_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [6:0]         id_opcode,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_alu_src,
    input  logic               id_mem_write,
    input  logic               id_mem_read,
    input  logic               id_wb_reg_file,
    input  logic               id_memtoreg,
    input  logic               id_branch,
    input  logic               id_jal,
    input  logic               id_jalr,
    input  logic [2:0]         id_mem_load_type,
    input  logic [1:0]         id_mem_store_type,
    input  logic [3:0]         id_alu_ctrl,
    input  logic               stall_in,
    input  logic               flush,
    output logic               hazard_stall,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [RADDR_W-1:0] ex_rs1,
    output logic [RADDR_W-1:0] ex_rs2,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_alu_src,
    output logic               ex_mem_write,
    output logic               ex_mem_read,
    output logic               ex_wb_reg_file,
    output logic               ex_memtoreg,
    output logic               ex_branch,
    output logic               ex_jal,
    output logic               ex_jalr,
    output logic [2:0]         ex_mem_load_type,
    output logic [1:0]         ex_mem_store_type,
`ifdef ID_EX_PERF_EN
    output logic [31:0]        perf_bubble_cnt,
    output logic [31:0]        perf_flush_cnt,
`endif
    output logic [3:0]         ex_alu_ctrl
);

    ctrl_bundle_t       id_ctrl;
    ctrl_bundle_t       ctrl_q;
    logic               valid_q;
    logic [XLEN-1:0]    pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [RADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic               hz;

    assign id_ctrl = '{
        alu_src:        id_alu_src,
        mem_write:      id_mem_write,
        mem_read:       id_mem_read,
        wb_reg_file:    id_wb_reg_file,
        memtoreg:       id_memtoreg,
        branch:         id_branch,
        jal:            id_jal,
        jalr:           id_jalr,
        mem_load_type:  id_mem_load_type,
        mem_store_type: id_mem_store_type,
        alu_ctrl:       id_alu_ctrl
    };

    load_use_detect #(.RADDR_W(RADDR_W)) u_lud (
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (rd_q),
        .hz          (hz)
    );

    // A flush already inserts the bubble, and a held register cannot take one.
    assign hazard_stall = hz & ~flush & ~stall_in;

    // Pipeline register: reset > hold > flush/hazard bubble > load.
    always_ff @(posedge clk) begin
        if (rst || (!stall_in && (flush || hz))) begin
            valid_q    <= 1'b0;
            ctrl_q     <= BUBBLE_CTRL;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else if (!stall_in) begin
            valid_q    <= id_valid;
            // Invalid entries never carry live control, only raw fields.
            ctrl_q     <= id_valid ? id_ctrl : BUBBLE_CTRL;
            pc_q       <= id_pc;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rd_q       <= id_rd;
        end
    end

    assign ex_valid          = valid_q;
    assign ex_pc             = pc_q;
    assign ex_rs1_data       = rs1_data_q;
    assign ex_rs2_data       = rs2_data_q;
    assign ex_imm            = imm_q;
    assign ex_rs1            = rs1_q;
    assign ex_rs2            = rs2_q;
    assign ex_rd             = rd_q;
    assign ex_alu_src        = ctrl_q.alu_src;
    assign ex_mem_write      = ctrl_q.mem_write;
    assign ex_mem_read       = ctrl_q.mem_read;
    assign ex_wb_reg_file    = ctrl_q.wb_reg_file;
    assign ex_memtoreg       = ctrl_q.memtoreg;
    assign ex_branch         = ctrl_q.branch;
    assign ex_jal            = ctrl_q.jal;
    assign ex_jalr           = ctrl_q.jalr;
    assign ex_mem_load_type  = ctrl_q.mem_load_type;
    assign ex_mem_store_type = ctrl_q.mem_store_type;
    assign ex_alu_ctrl       = ctrl_q.alu_ctrl;

`ifdef ID_EX_PERF_EN
    logic [31:0] perf_bubble_q;
    logic [31:0] perf_flush_q;

    // Saturating event counters; nothing is counted while the register holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bubble_q <= '0;
            perf_flush_q  <= '0;
        end else if (!stall_in) begin
            if (flush && (perf_flush_q != 32'hFFFF_FFFF)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
            if (!flush && hz && (perf_bubble_q != 32'hFFFF_FFFF)) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_bubble_cnt = perf_bubble_q;
    assign perf_flush_cnt  = perf_flush_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg.
// Build with ID_EX_PERF_EN defined to also exercise the perf counters.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_alu_src, id_mem_write, id_mem_read, id_wb_reg_file;
    logic        id_memtoreg, id_branch, id_jal, id_jalr;
    logic [2:0]  id_mem_load_type;
    logic [1:0]  id_mem_store_type;
    logic [3:0]  id_alu_ctrl;
    logic        stall_in, flush;
    logic        hazard_stall, ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_alu_src, ex_mem_write, ex_mem_read, ex_wb_reg_file;
    logic        ex_memtoreg, ex_branch, ex_jal, ex_jalr;
    logic [2:0]  ex_mem_load_type;
    logic [1:0]  ex_mem_store_type;
    logic [3:0]  ex_alu_ctrl;
`ifdef ID_EX_PERF_EN
    logic [31:0] perf_bubble_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] LD_OP  = 7'b0000011;
    localparam logic [6:0] ST_OP  = 7'b0100011;
    localparam logic [6:0] LUI_OP = 7'b0110111;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_mem_write(id_mem_write),
        .id_mem_read(id_mem_read), .id_wb_reg_file(id_wb_reg_file),
        .id_memtoreg(id_memtoreg), .id_branch(id_branch), .id_jal(id_jal),
        .id_jalr(id_jalr), .id_mem_load_type(id_mem_load_type),
        .id_mem_store_type(id_mem_store_type), .id_alu_ctrl(id_alu_ctrl),
        .stall_in(stall_in), .flush(flush), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_src(ex_alu_src),
        .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
        .ex_wb_reg_file(ex_wb_reg_file), .ex_memtoreg(ex_memtoreg),
        .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .ex_mem_load_type(ex_mem_load_type),
        .ex_mem_store_type(ex_mem_store_type),
`ifdef ID_EX_PERF_EN
        .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .ex_alu_ctrl(ex_alu_ctrl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction; data fields derive from pc so every field is distinct.
    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd,
                         input logic [31:0] pc, input logic mr, input logic wb);
        id_valid          = v;
        id_opcode         = op;
        id_rs1            = r1;
        id_rs2            = r2;
        id_rd             = rd;
        id_pc             = pc;
        id_rs1_data       = pc + 32'h1000;
        id_rs2_data       = pc + 32'h2000;
        id_imm            = pc + 32'h3000;
        id_mem_read       = mr;
        id_memtoreg       = mr;
        id_alu_src        = mr;
        id_wb_reg_file    = wb;
        id_mem_write      = 1'b0;
        id_branch         = 1'b0;
        id_jal            = 1'b0;
        id_jalr           = 1'b0;
        id_mem_load_type  = mr ? 3'b010 : 3'b100;
        id_mem_store_type = 2'b00;
        id_alu_ctrl       = pc[5:2];
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_ctrl"}, 32'({ex_alu_src, ex_mem_write, ex_mem_read, ex_wb_reg_file,
                                 ex_memtoreg, ex_branch, ex_jal, ex_jalr}), 32'd0);
        chk({tag, "_ldtype"}, 32'(ex_mem_load_type), 32'd2);
        chk({tag, "_sttype"}, 32'(ex_mem_store_type), 32'd2);
        chk({tag, "_alu"}, 32'(ex_alu_ctrl), 32'd0);
        chk({tag, "_data"}, ex_pc | ex_rs1_data | ex_rs2_data | ex_imm, 32'd0);
        chk({tag, "_addr"}, 32'({ex_rs1, ex_rs2, ex_rd}), 32'd0);
    endtask

    initial begin
        // Reset with random inputs, and stall_in/flush asserted to show rst wins.
        rst = 1'b1; stall_in = 1'b1; flush = 1'b1;
        drive(1'b1, R_OP, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'b1, 1'b1);
        id_mem_write = 1'b1; id_branch = 1'b1; id_jal = 1'b1; id_jalr = 1'b1;
        tick();
        tick();
        chk_bubble("reset");
        rst = 1'b0; stall_in = 1'b0; flush = 1'b0;

        // ADD x3,x1,x2 passes through with 1-cycle latency.
        drive(1'b1, R_OP, 5'd1, 5'd2, 5'd3, 32'h100, 1'b0, 1'b1);
        #1 chk("add_no_hz", 32'(hazard_stall), 32'd0);
        tick();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_rd", 32'(ex_rd), 32'd3);
        chk("add_pc", ex_pc, 32'h100);
        chk("add_alu", 32'(ex_alu_ctrl), 32'd0);
        chk("add_wb", 32'(ex_wb_reg_file), 32'd1);
        chk("add_rs1d", ex_rs1_data, 32'h1100);
        chk("add_imm", ex_imm, 32'h3100);
        chk("add_ldtype", 32'(ex_mem_load_type), 32'd4);

        // LW x5 then ADD x6,x5,x7: one bubble, then the ADD advances.
        drive(1'b1, LD_OP, 5'd1, 5'd0, 5'd5, 32'h104, 1'b1, 1'b1);
        tick();
        chk("lw_mr", 32'(ex_mem_read), 32'd1);
        drive(1'b1, R_OP, 5'd5, 5'd7, 5'd6, 32'h108, 1'b0, 1'b1);
        #1 chk("lu_hz", 32'(hazard_stall), 32'd1);
        tick();
        chk_bubble("lu_bubble");
        chk("lu_hz_drop", 32'(hazard_stall), 32'd0);
        tick();
        chk("lu_adv_valid", 32'(ex_valid), 32'd1);
        chk("lu_adv_rd", 32'(ex_rd), 32'd6);
        chk("lu_adv_pc", ex_pc, 32'h108);

        // rs2 dependency through a store.
        drive(1'b1, LD_OP, 5'd1, 5'd0, 5'd5, 32'h10c, 1'b1, 1'b1);
        tick();
        drive(1'b1, ST_OP, 5'd1, 5'd5, 5'd0, 32'h110, 1'b0, 1'b0);
        #1 chk("st_rs2_hz", 32'(hazard_stall), 32'd1);
        tick();
        chk("st_bubble", 32'(ex_valid), 32'd0);
        tick();
        chk("st_adv", ex_pc, 32'h110);

        // Load into x0 never stalls.
        drive(1'b1, LD_OP, 5'd1, 5'd0, 5'd0, 32'h114, 1'b1, 1'b1);
        tick();
        drive(1'b1, R_OP, 5'd0, 5'd0, 5'd6, 32'h118, 1'b0, 1'b1);
        #1 chk("x0_no_hz", 32'(hazard_stall), 32'd0);
        tick();
        chk("x0_adv_valid", 32'(ex_valid), 32'd1);
        chk("x0_adv_pc", ex_pc, 32'h118);

        // LUI does not read rs1 even if the field matches.
        drive(1'b1, LD_OP, 5'd1, 5'd0, 5'd5, 32'h11c, 1'b1, 1'b1);
        tick();
        drive(1'b1, LUI_OP, 5'd5, 5'd5, 5'd6, 32'h120, 1'b0, 1'b1);
        #1 chk("lui_no_hz", 32'(hazard_stall), 32'd0);
        tick();
        chk("lui_adv_pc", ex_pc, 32'h120);

        // Flush together with a hazard: single bubble, no stall request.
        drive(1'b1, LD_OP, 5'd1, 5'd0, 5'd5, 32'h124, 1'b1, 1'b1);
        tick();
        drive(1'b1, R_OP, 5'd5, 5'd7, 5'd6, 32'h128, 1'b0, 1'b1);
        flush = 1'b1;
        #1 chk("fl_hz_masked", 32'(hazard_stall), 32'd0);
        tick();
        chk_bubble("fl_bubble");
        flush = 1'b0;

        // Hold under stall_in with flush high and changing inputs.
        drive(1'b1, R_OP, 5'd1, 5'd2, 5'd9, 32'h200, 1'b0, 1'b1);
        tick();
        chk("hold_setup_rd", 32'(ex_rd), 32'd9);
        stall_in = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, R_OP, 5'(i + 10), 5'd2, 5'(i + 20), 32'h300 + 32'(i * 4), 1'b1, 1'b1);
            tick();
            chk("hold_pc", ex_pc, 32'h200);
            chk("hold_rd", 32'(ex_rd), 32'd9);
            chk("hold_valid", 32'(ex_valid), 32'd1);
            chk("hold_mr", 32'(ex_mem_read), 32'd0);
        end
        stall_in = 1'b0;
        tick();
        chk_bubble("hold_release");
        flush = 1'b0;

        // id_valid=0: fields load as presented, control forced to bubble.
        drive(1'b0, LD_OP, 5'd1, 5'd0, 5'd12, 32'h300, 1'b1, 1'b1);
        tick();
        chk("inv_valid", 32'(ex_valid), 32'd0);
        chk("inv_rd", 32'(ex_rd), 32'd12);
        chk("inv_pc", ex_pc, 32'h300);
        chk("inv_mr", 32'(ex_mem_read), 32'd0);
        chk("inv_wb", 32'(ex_wb_reg_file), 32'd0);
        chk("inv_ldtype", 32'(ex_mem_load_type), 32'd2);
        drive(1'b1, R_OP, 5'd12, 5'd12, 5'd13, 32'h304, 1'b0, 1'b1);
        #1 chk("inv_no_hz", 32'(hazard_stall), 32'd0);

`ifdef ID_EX_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("perf_rst_b", perf_bubble_cnt, 32'd0);
        chk("perf_rst_f", perf_flush_cnt, 32'd0);
        // Four hazard bubbles.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, LD_OP, 5'd1, 5'd0, 5'd5, 32'h400, 1'b1, 1'b1);
            tick();
            drive(1'b1, R_OP, 5'd5, 5'd7, 5'd6, 32'h404, 1'b0, 1'b1);
            tick();
            tick();
        end
        // Hazard presented while held: not counted.
        drive(1'b1, LD_OP, 5'd1, 5'd0, 5'd5, 32'h408, 1'b1, 1'b1);
        tick();
        drive(1'b1, R_OP, 5'd5, 5'd7, 5'd6, 32'h40c, 1'b0, 1'b1);
        stall_in = 1'b1;
        tick();
        stall_in = 1'b0;
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        chk("perf_bubbles", perf_bubble_cnt, 32'd4);
        chk("perf_flushes", perf_flush_cnt, 32'd2);
        // Saturation.
        @(negedge clk);
        force dut.perf_flush_q = 32'hFFFF_FFFF;
        #1 release dut.perf_flush_q;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("perf_sat", perf_flush_cnt, 32'hFFFF_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register for the 5-stage RV32I core. It sits directly downstream of the decode-stage control unit and captures its control bundle, operands, immediate and register addresses for the EX stage. It also contains the load-use hazard detector. It inserts bubbles on hazard or flush and holds its contents on a downstream stall.

Parameters:
XLEN, 32, data/PC width
RADDR_W, 5, register-address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_opcode  in  7  instruction opcode, used for rs-usage decode
id_pc  in  XLEN  instruction PC
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  in  RADDR_W  register addresses
id_alu_src, id_mem_write, id_mem_read, id_wb_reg_file, id_memtoreg, id_branch, id_jal, id_jalr  in  1 each  control-unit outputs
id_mem_load_type  in  3  load type
id_mem_store_type  in  2  store type
id_alu_ctrl  in  4  ALU op
stall_in  in  1  downstream (MEM) stall; hold register
flush  in  1  EX redirect (taken branch/jump); kill the ID instruction
hazard_stall  out  1  freeze PC and IF/ID this cycle
ex_valid  out  1  registered valid
ex_*  out  same widths as id_*  registered copies of every id_* input except id_opcode

Behaviour:
- Reset (rst=1 at a clock edge): load the bubble value. The bubble is ex_valid=0, all 1-bit controls 0, ex_mem_load_type=3'b010, ex_mem_store_type=2'b10, ex_alu_ctrl=0, and all data, PC, imm and address fields 0. rst overrides every other input.
- rs-usage decode (combinational, from id_opcode):
  - rs1_used = 1 except for LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2_used = 1 only for R-type (0110011), STORE (0100011) and BRANCH (1100011).
  - Any unknown opcode gives rs1_used=rs2_used=0.
- Load-use detect (combinational):
  - hz = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((rs1_used & id_rs1==ex_rd) | (rs2_used & id_rs2==ex_rd)).
  - hazard_stall = hz & ~flush & ~stall_in.
- Register update priority at each edge:
  1. rst: load bubble.
  2. stall_in: hold all contents. flush is ignored because the EX source keeps asserting it while held.
  3. flush: load bubble.
  4. hz: load bubble; the upstream stages hold the instruction in ID.
  5. Otherwise: load the id_* inputs, with ex_valid=id_valid.
- id_valid=0 loads the fields as presented with ex_valid=0. Control outputs are additionally forced to their bubble values whenever ex_valid=0, so downstream stages never see a write-enable from an invalid entry.
- Latency is 1 cycle. A load-use hazard costs exactly 1 bubble: the next cycle EX holds a bubble (ex_mem_read=0), so hz drops and the instruction advances.
- A load with rd=x0 never causes a hazard.
- flush and hz in the same cycle: a single bubble is inserted and hazard_stall=0.

Optional Feature:
ID_EX_PERF_EN
- Defined: adds outputs perf_bubble_cnt (32) and perf_flush_cnt (32), both reset to 0.
  - perf_bubble_cnt increments on each edge that takes priority 4.
  - perf_flush_cnt increments on each edge that takes priority 3.
  - Neither counter increments while stall_in=1. Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package rv_pipe_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - LOAD_TYPE_DEFAULT=3'b010 and STORE_TYPE_DEFAULT=2'b10;
  - a packed ctrl_bundle_t struct and its BUBBLE_CTRL constant.
- One sub-module: load_use_detect (rs-usage decode plus the hz equation), kept purely combinational.

Test Plan:
1. Reset: rst=1 for 2 cycles with random id_* inputs -> ex_valid=0, ex_mem_load_type=3'b010, ex_mem_store_type=2'b10, all other outputs 0.
2. Pass-through: ADD x3,x1,x2 (id_alu_ctrl=0000, id_wb_reg_file=1, id_pc=0x100) -> next cycle ex_valid=1, ex_rd=3, ex_pc=0x100, ex_alu_ctrl=0000.
3. Load-use:
   - Stimulus: EX holds LW x5 (ex_mem_read=1); ID holds ADD x6,x5,x7.
   - Required: hazard_stall=1 for exactly 1 cycle; next edge EX=bubble; the following edge loads the ADD.
   - Repeat with ex_rd=0 -> no stall. Repeat with ID=LUI x6 -> no stall.
4. Flush vs hazard: same setup as 3 plus flush=1 -> hazard_stall=0 and EX=bubble.
5. stall_in=1 for 3 cycles with flush=1 and changing id_* -> ex_* unchanged throughout. On release with flush still 1 -> bubble.
6. ID_EX_PERF_EN: 4 hazard bubbles and 2 flushes, plus one hazard under stall_in -> perf_bubble_cnt=4, perf_flush_cnt=2. Force a counter to 32'hFFFF_FFFF, then trigger another event -> it stays at 32'hFFFF_FFFF.
